reg_pipe: RTL and testbench

Parametrised multi-stage valid/ready register pipeline, and the general-purpose successor to the single-bit flop variants. It delays a WIDTH-bit payload by DEPTH register stages, applies backpressure and collapses bubbles. Control state uses async reset. The data-register reset style (none, synchronous, asynchronous) is selectable per instance. It is used wherever the design needs retiming or fixed latency with flow control.

---
 rtl/dff_pkg.sv | 16 +
 rtl/reg_pipe_stage.sv | 72 +++++++
 rtl/reg_pipe.sv | 87 ++++++++
 tb/tb_reg_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_pkg
// Brief    : Shared definitions for flop-style blocks (data reset style select)
// Revision : 1.0 - initial release
// ============================================================================
package dff_pkg;

    typedef enum logic [1:0] {
        RST_NONE  = 2'd0,
        RST_SYNC  = 2'd1,
        RST_ASYNC = 2'd2
    } rst_mode_e;

endpackage
`default_nettype wire

// File: rtl/reg_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe_stage
// Brief    : One valid/data stage of reg_pipe with selectable data reset style
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe_stage
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH    = 8,
    parameter rst_mode_e         DATA_RST = RST_ASYNC,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Data only captures real payloads so an idle stage keeps its last value.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            if (DATA_RST == RST_SYNC) begin
                data_d = RST_VAL;
            end
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    if (DATA_RST == RST_ASYNC) begin : g_data_async
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= RST_VAL;
            end else begin
                data_q <= data_d;
            end
        end
    end else begin : g_data_plain
        always_ff @(posedge clk) begin
            data_q <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : reg_pipe
// Brief    : DEPTH-stage valid/ready register pipeline with bubble collapsing
// Revision : 1.0 - initial release
// ============================================================================
module reg_pipe
    import dff_pkg::*;
#(
    parameter int unsigned       WIDTH    = 8,
    parameter int unsigned       DEPTH    = 3,
    parameter rst_mode_e         DATA_RST = RST_ASYNC,
    parameter logic [WIDTH-1:0]  RST_VAL  = '0,
    localparam int unsigned      OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [OCC_W-1:0] occupancy_o
);

    if (DEPTH < 1 || WIDTH < 1) begin : g_param_check
        $error("reg_pipe: DEPTH and WIDTH must both be at least 1");
    end

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0]            rdy;
    logic [OCC_W-1:0]            occ;

    // Ready ripples back from the output; an empty stage is always ready.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = !valid_q[DEPTH-1] || out_ready_i;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            rdy[k] = !valid_q[k] || rdy[k+1];
        end
    end

    always_comb begin
        occ = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(valid_q[k]);
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             stage_valid_in;
        logic [WIDTH-1:0] stage_data_in;

        if (k == 0) begin : g_head
            assign stage_valid_in = in_valid_i;
            assign stage_data_in  = in_data_i;
        end else begin : g_body
            assign stage_valid_in = valid_q[k-1];
            assign stage_data_in  = data_q[k-1];
        end

        reg_pipe_stage #(
            .WIDTH    (WIDTH),
            .DATA_RST (DATA_RST),
            .RST_VAL  (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .flush_i (flush_i),
            .load_i  (rdy[k]),
            .valid_i (stage_valid_in),
            .data_i  (stage_data_in),
            .valid_o (valid_q[k]),
            .data_o  (data_q[k])
        );
    end

    assign in_ready_o  = rdy[0] && !flush_i;
    assign out_valid_o = valid_q[DEPTH-1] && !flush_i;
    assign out_data_o  = data_q[DEPTH-1];
    assign occupancy_o = occ;

endmodule
`default_nettype wire

// File: tb/tb_reg_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_pipe
// Brief    : Directed self-checking bench for reg_pipe with a FIFO scoreboard
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_pipe;
    import dff_pkg::*;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 3;
    localparam logic [7:0]  RVAL  = 8'hA5;

    logic       clk;
    logic       reset_n;
    logic       flush_i;
    logic       in_valid_i;
    logic [7:0] in_data_i;
    logic       out_ready_i;

    logic       in_ready_a,  out_valid_a;
    logic [7:0] out_data_a;
    logic [1:0] occ_a;
    logic       in_ready_s,  out_valid_s;
    logic [7:0] out_data_s;
    logic [1:0] occ_s;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_RST(RST_ASYNC), .RST_VAL(RVAL)) dut (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_a), .in_data_i(in_data_i),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready_i), .out_data_o(out_data_a),
        .occupancy_o(occ_a)
    );

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_RST(RST_SYNC), .RST_VAL(RVAL)) dut_s (
        .clk(clk), .reset_n(reset_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_s), .in_data_i(in_data_i),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_i), .out_data_o(out_data_s),
        .occupancy_o(occ_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshakes seen at the falling edge are the ones the next rising edge commits.
    always @(negedge clk) begin
        if (!reset_n || flush_i) begin
            exp_q.delete();
        end else begin
            if (out_valid_a && out_ready_i) begin
                chk("sb_pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("sb_data", 32'(out_data_a), 32'(exp_q.pop_front()));
                end
            end
            if (in_valid_i && in_ready_a) begin
                exp_q.push_back(in_data_i);
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = 8'h00;
        out_ready_i = 1'b0;

        // Reset
        step();
        step();
        chk("rst_out_valid", 32'(out_valid_a), 32'd0);
        chk("rst_out_data",  32'(out_data_a),  32'(RVAL));
        chk("rst_occupancy", 32'(occ_a),       32'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 32'd1);
        step();

        // Streaming: first payload visible after the third edge, then one per cycle
        out_ready_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i);
            #1;
            chk("stream_in_ready", 32'(in_ready_a), 32'd1);
            step();
            chk("stream_out_valid", 32'(out_valid_a), 32'(i >= 3));
            if (i >= 3) chk("stream_out_data", 32'(out_data_a), 32'(i - 2));
        end
        in_valid_i = 1'b0;
        for (int i = 4; i <= 5; i++) begin
            step();
            chk("stream_tail_data", 32'(out_data_a), 32'(i));
        end
        step();
        chk("stream_drained", 32'(out_valid_a), 32'd0);

        // Backpressure
        out_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i);
            step();
        end
        chk("bp_occupancy_full", 32'(occ_a), 32'd3);
        in_data_i = 8'h04;
        #1;
        chk("bp_in_ready_low", 32'(in_ready_a), 32'd0);
        step();
        chk("bp_held_occupancy", 32'(occ_a), 32'd3);
        out_ready_i = 1'b1;
        #1;
        chk("bp_in_ready_comb", 32'(in_ready_a), 32'd1);
        step();
        in_valid_i = 1'b0;
        chk("bp_push_pop_occ", 32'(occ_a), 32'd3);
        for (int i = 2; i <= 4; i++) begin
            chk("bp_out_data", 32'(out_data_a), 32'(i));
            step();
        end
        chk("bp_drained", 32'(out_valid_a), 32'd0);

        // Bubble collapse
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 8'hAA;
        step();
        in_valid_i  = 1'b0;
        step();
        in_valid_i  = 1'b1;
        in_data_i   = 8'hBB;
        step();
        in_valid_i  = 1'b0;
        step();
        chk("bubble_occupancy", 32'(occ_a), 32'd2);
        chk("bubble_head_data", 32'(out_data_a), 32'hAA);
        out_ready_i = 1'b1;
        step();
        chk("bubble_second_valid", 32'(out_valid_a), 32'd1);
        chk("bubble_second_data", 32'(out_data_a), 32'hBB);
        step();
        chk("bubble_drained", 32'(out_valid_a), 32'd0);

        // Flush
        out_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(i * 17);
            step();
        end
        chk("flush_pre_occ", 32'(occ_s), 32'd3);
        flush_i   = 1'b1;
        in_data_i = 8'h44;
        #1;
        chk("flush_in_ready",    32'(in_ready_s),  32'd0);
        chk("flush_out_valid",   32'(out_valid_s), 32'd0);
        chk("flush_in_ready_a",  32'(in_ready_a),  32'd0);
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("flush_occ_sync",    32'(occ_s),      32'd0);
        chk("flush_occ_async",   32'(occ_a),      32'd0);
        chk("flush_data_sync",   32'(out_data_s), 32'(RVAL));
        chk("flush_data_hold",   32'(out_data_a), 32'h11);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("flush_no_output", 32'(out_valid_s), 32'd0);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'(8'h61 + i);
            step();
        end
        chk("arst_pre_valid", 32'(out_valid_a), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid_a), 32'd0);
        chk("arst_occupancy", 32'(occ_a),       32'd0);
        chk("arst_out_data",  32'(out_data_a),  32'(RVAL));
        step();
        reset_n   = 1'b1;
        in_data_i = 8'h70;
        step();
        in_valid_i = 1'b0;
        chk("arst_lat_e0", 32'(out_valid_a), 32'd0);
        step();
        chk("arst_lat_e1", 32'(out_valid_a), 32'd0);
        step();
        chk("arst_lat_e2", 32'(out_valid_a), 32'd1);
        chk("arst_lat_data", 32'(out_data_a), 32'h70);
        step();
        step();

        chk("sb_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
